instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction encoder and program streamer for the single-cycle MIPS core. It accepts one decoded instruction per handshake: a one-hot class select plus register and immediate fields. It packs each accepted instruction into a 32-bit MIPS word, buffers it in a small FIFO, and streams it out with an auto-incrementing word address for loading instruction memory. It is the inverse of the opcode/funct decode stage: it covers the same nine instructions, and its select vector uses the same flag order.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `BASE_ADDR`, 32'h0000_3000: first output address; also the address after `clr`.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `clr`  in  1  synchronous flush; empties FIFO, reloads address.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  encoder can accept.
- `in_sel`  in  9  one-hot class, bit 0..8 = ori, lw, sw, beq, lui, jal, addu, subu, jr.
- `in_rs`, `in_rt`, `in_rd`  in  5 each  register fields.
- `in_imm`  in  16  immediate / branch offset.
- `in_target`  in  26  jal target.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  32  encoded word.
- `out_addr`  out  32  byte address for `out_data`.
- `err_cnt`  out  8  count of rejected selects, saturating.
- `word_cnt`  out  16  words emitted since reset/clr, wraps.

## Operation
- Accept on `in_valid && in_ready`; `in_ready = !full && !clr`.
- Encoding fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6]=0, funct[5:0].
  - ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04: {op, rs, rt, imm}.
  - lui forces rs=0.
  - jal 0x03: {op, target}.
  - addu / subu: op 0x00, funct 0x21 / 0x23, {rs, rt, rd}.
  - jr: op 0x00, funct 0x08, rs only; rt=rd=0.
- Unused fields are zeroed regardless of input values.
- Select not exactly one-hot (zero or multiple bits) on an accepted cycle:
  - word is dropped and nothing is pushed;
  - `err_cnt` increments, saturating at 255.
- Output pop on `out_valid && out_ready`:
  - `out_addr` += 4, wrapping modulo 2^32;
  - `word_cnt` += 1.
- `out_addr` always shows the address of the current head word.
- `clr`: FIFO emptied, `out_addr` ← BASE_ADDR, `word_cnt` ← 0, `err_cnt` kept. The pop and push in the same cycle are both suppressed.
- State: FIFO pointers plus an occupancy count (states EMPTY / PARTIAL / FULL derived from count).
  - Push only: count+1. Pop only: count−1. Push and pop together: count unchanged, both performed.
  - FULL with a pop in the same cycle: `in_ready` is still 0 that cycle; no pass-through.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_addr`=BASE_ADDR, `err_cnt`=0, `word_cnt`=0, `in_ready`=1, FIFO empty.
- Latency: input accepted at edge N → `out_valid`=1 with the encoded word after edge N (visible in cycle N+1). No combinational path from `in_*` to `out_*`.
- `out_data`/`out_addr` stay stable while `out_valid && !out_ready`.
- Reset or `clr` mid-stream drops all buffered words; the first word after that is emitted at BASE_ADDR.
- Encoding is combinational before the FIFO write; `out_data` comes straight from the FIFO register (registered output).

## Structure
- Package `mips_isa_pkg`:
  - opcode constants OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_JAL, OP_R;
  - funct constants FN_ADDU, FN_SUBU, FN_JR;
  - select bit-index constants;
  - shared with the decoder so the flag orders stay identical.
- Sub-module `sync_fifo` (parameter WIDTH, DEPTH; push/pop/full/empty/flush).
- Top level holds the encoder mux, the address counter and the error/word counters.

## Test plan
- Single-word encodes, each checked against `out_data`, with `out_addr`=0x3000 on the first:
  - ori rt=8 imm=0x1234 → 0x34081234.
  - addu rs=1 rt=2 rd=3 → 0x00221821.
  - lui rt=1 imm=0xFFFF (rs=7 ignored) → 0x3C01FFFF.
  - jr rs=31 (rd=5 ignored) → 0x03E00008.
- Burst of lw rs=29 rt=8 imm=4, beq rs=1 rt=2 imm=0xFFFE, jal target=0xC00, with `out_ready`=1:
  - → 0x8FA80004 @0x3000, 0x1022FFFE @0x3004, 0x0C000C00 @0x3008;
  - `word_cnt`=3.
- Backpressure, `DEPTH`=4, `out_ready`=0, five pushes:
  - `in_ready` falls after the 4th accept;
  - 5th is held by the source;
  - release drains in order, then the 5th word follows.
- Invalid select: `in_sel`=9'b000000011, then 9'b0 → `err_cnt`=2, `out_valid` stays 0, `in_ready` stays 1.
- `clr` with 3 words queued and simultaneous push/pop:
  - next cycle FIFO empty, `word_cnt`=0;
  - next accepted word emitted at 0x3000.
- `reset` asserted mid-burst: all outputs return to reset values in the following cycle.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: shared MIPS ISA constants for the encoder and the
// opcode/funct decoder, so both sides agree on the class-select flag order.
// Contents: opcode / funct constants, select bit indices, field struct,
// a one-hot test and the combinational instruction packer.
package mips_isa_pkg;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  // Select vector bit positions (same order as the decoder's flags).
  localparam int SEL_W    = 9;
  localparam int SEL_ORI  = 0;
  localparam int SEL_LW   = 1;
  localparam int SEL_SW   = 2;
  localparam int SEL_BEQ  = 3;
  localparam int SEL_LUI  = 4;
  localparam int SEL_JAL  = 5;
  localparam int SEL_ADDU = 6;
  localparam int SEL_SUBU = 7;
  localparam int SEL_JR   = 8;

  typedef logic [SEL_W-1:0] sel_t;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
  } instr_fields_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_PARTIAL,
    FIFO_FULL
  } fifo_state_e;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input sel_t s);
    return (s != '0) && ((s & (s - sel_t'(1))) == '0);
  endfunction

  // Packs one instruction. Only meaningful for a one-hot select; any field the
  // format does not use is forced to zero.
  function automatic logic [31:0] encode(input sel_t sel, input instr_fields_t f);
    logic [31:0] w;
    w = '0;
    if (sel[SEL_ORI])       w = {OP_ORI, f.rs, f.rt, f.imm};
    else if (sel[SEL_LW])   w = {OP_LW,  f.rs, f.rt, f.imm};
    else if (sel[SEL_SW])   w = {OP_SW,  f.rs, f.rt, f.imm};
    else if (sel[SEL_BEQ])  w = {OP_BEQ, f.rs, f.rt, f.imm};
    else if (sel[SEL_LUI])  w = {OP_LUI, 5'd0, f.rt, f.imm};
    else if (sel[SEL_JAL])  w = {OP_JAL, f.target};
    else if (sel[SEL_ADDU]) w = {OP_R, f.rs, f.rt, f.rd, 5'd0, FN_ADDU};
    else if (sel[SEL_SUBU]) w = {OP_R, f.rs, f.rt, f.rd, 5'd0, FN_SUBU};
    else if (sel[SEL_JR])   w = {OP_R, f.rs, 15'd0, FN_JR};
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and flush.
// Ports: clk, reset (sync, active-high), flush_i (empties the FIFO),
// push_i / wdata_i (write side), pop_i / rdata_o (read side, rdata_o is the
// head entry straight from storage), full_o, empty_o.
// Push while full and pop while empty are ignored; flush beats push and pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] wr_en;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !flush_i && !full_o;
  assign do_pop  = pop_i && !flush_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = do_push && (wr_ptr_q == AW'(gi));
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) mem_q[i] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instructions into 32-bit MIPS words, queues
// them and streams them out with an auto-incrementing byte address.
// Ports: clk, reset (sync, active-high), clr (flush + address reload);
// input handshake in_valid/in_ready with in_sel (one-hot class), in_rs,
// in_rt, in_rd, in_imm, in_target; output handshake out_valid/out_ready with
// out_data and out_addr; err_cnt (saturating rejected-select count) and
// word_cnt (words emitted since reset/clr, wrapping).
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_sel,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr,
  output logic [7:0]  err_cnt,
  output logic [15:0] word_cnt
);
  import mips_isa_pkg::*;

  logic          fifo_full, fifo_empty;
  fifo_state_e   fifo_state;
  logic          accept, sel_ok, push, pop;
  logic [31:0]   enc_word;
  instr_fields_t fields;

  logic [31:0] addr_q, addr_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    if (fifo_empty)     fifo_state = FIFO_EMPTY;
    else if (fifo_full) fifo_state = FIFO_FULL;
    else                fifo_state = FIFO_PARTIAL;
  end

  // A full FIFO never accepts, even when the head is popped this cycle.
  assign in_ready  = (fifo_state != FIFO_FULL) && !clr;
  assign out_valid = (fifo_state != FIFO_EMPTY);
  assign accept    = in_valid && in_ready;
  assign sel_ok    = is_onehot(in_sel);
  assign push      = accept && sel_ok;
  assign pop       = out_valid && out_ready && !clr;

  assign fields   = '{rs: in_rs, rt: in_rt, rd: in_rd, imm: in_imm, target: in_target};
  assign enc_word = encode(in_sel, fields);

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (clr),
    .push_i  (push),
    .wdata_i (enc_word),
    .pop_i   (pop),
    .rdata_o (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (clr) begin
      addr_d     = BASE_ADDR;
      word_cnt_d = '0;
    end else if (pop) begin
      addr_d     = addr_q + 32'd4;
      word_cnt_d = word_cnt_q + 16'd1;
    end
    if (accept && !sel_ok && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= BASE_ADDR;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_addr = addr_q;
  assign word_cnt = word_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  // Opcode / funct per select bit (ori, lw, sw, beq, lui, jal, addu, subu, jr).
  localparam int unsigned OPC[9] = '{13, 35, 43, 4, 15, 3, 0, 0, 0};
  localparam int unsigned FNC[9] = '{0, 0, 0, 0, 0, 0, 33, 35, 8};
  localparam longint unsigned P26 = 64'd67108864;
  localparam longint unsigned P21 = 64'd2097152;
  localparam longint unsigned P16 = 64'd65536;
  localparam longint unsigned P11 = 64'd2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clr, in_valid, in_ready, out_valid, out_ready;
  logic [8:0]  in_sel;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic [31:0] out_data, out_addr;
  logic [7:0]  err_cnt;
  logic [15:0] word_cnt;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .err_cnt(err_cnt), .word_cnt(word_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [31:0] m_q[$];
  logic [31:0] m_addr;
  logic [15:0] m_wc;
  logic [7:0]  m_ec;
  bit          last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_encode(input logic [8:0] sel, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    longint unsigned w;
    int k;
    k = 0;
    for (int i = 0; i < 9; i++) if (sel[i]) k = i;
    case (k)
      0, 1, 2, 3: w = OPC[k] * P26 + rs * P21 + rt * P16 + 64'(imm);
      4:          w = OPC[k] * P26 + rt * P16 + 64'(imm);
      5:          w = OPC[k] * P26 + 64'(tgt);
      6, 7:       w = rs * P21 + rt * P16 + rd * P11 + FNC[k];
      default:    w = rs * P21 + FNC[k];
    endcase
    return w[31:0];
  endfunction

  // One clock cycle: compare DUT against the model, then advance the model.
  task automatic step();
    bit m_ready, acc, pop;
    #1;
    m_ready = (m_q.size() < DEPTH) && !clr;
    chk("in_ready", in_ready, m_ready);
    chk("out_valid", out_valid, m_q.size() != 0);
    chk("out_addr", out_addr, m_addr);
    chk("word_cnt", word_cnt, m_wc);
    chk("err_cnt", err_cnt, m_ec);
    if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
    acc = in_valid && m_ready && !reset;
    pop = (m_q.size() != 0) && out_ready && !clr && !reset;
    last_acc = acc;
    if (pop) $display("pop  data=%h addr=%h", m_q[0], m_addr);
    if (acc) $display("push sel=%b rs=%0d rt=%0d rd=%0d imm=%h tgt=%h",
                      in_sel, in_rs, in_rt, in_rd, in_imm, in_target);
    @(posedge clk);
    #1;
    if (reset) begin
      m_q.delete(); m_addr = BASE; m_wc = '0; m_ec = '0;
    end else if (clr) begin
      m_q.delete(); m_addr = BASE; m_wc = '0;
    end else begin
      if (pop) begin
        void'(m_q.pop_front());
        m_addr = m_addr + 32'd4;
        m_wc   = m_wc + 16'd1;
      end
      if (acc) begin
        if ($countones(in_sel) == 1)
          m_q.push_back(ref_encode(in_sel, in_rs, in_rt, in_rd, in_imm, in_target));
        else if (m_ec != 8'hFF)
          m_ec = m_ec + 8'd1;
      end
    end
  endtask

  task automatic push(input logic [8:0] sel, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; in_sel = sel; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_target = tgt;
    for (int n = 0; n < 40 && !done; n++) begin
      step();
      done = last_acc;
    end
    in_valid = 1'b0;
    chk("push_accepted", done, 1'b1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 40 && m_q.size() != 0; n++) step();
    step();
    chk("drained_out_valid", out_valid, 1'b0);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sel = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    m_addr = BASE; m_wc = '0; m_ec = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    chk("rst_out_data", out_data, 32'h0);
    step();

    // Single-word encodes.
    out_ready = 1'b0;
    push(9'b000000001, 5'd0, 5'd8, 5'd9, 16'h1234, 26'h0);
    chk("ori_word", out_data, 32'h34081234);
    chk("ori_addr", out_addr, 32'h0000_3000);
    drain();
    out_ready = 1'b0;
    push(9'b001000000, 5'd1, 5'd2, 5'd3, 16'hBEEF, 26'h3FFFFFF);
    chk("addu_word", out_data, 32'h00221821);
    drain();
    out_ready = 1'b0;
    push(9'b000010000, 5'd7, 5'd1, 5'd4, 16'hFFFF, 26'h155);
    chk("lui_word", out_data, 32'h3C01FFFF);
    drain();
    out_ready = 1'b0;
    push(9'b100000000, 5'd31, 5'd3, 5'd5, 16'h7777, 26'h1);
    chk("jr_word", out_data, 32'h03E00008);
    drain();

    // Burst with the consumer always ready.
    clr_pulse();
    out_ready = 1'b1;
    push(9'b000000010, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
    push(9'b000001000, 5'd1, 5'd2, 5'd0, 16'hFFFE, 26'h0);
    push(9'b000100000, 5'd0, 5'd0, 5'd0, 16'h0, 26'hC00);
    drain();
    chk("burst_word_cnt", word_cnt, 16'd3);

    // Backpressure: four fill the FIFO, the fifth waits.
    clr_pulse();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(9'(1 << i), 5'(i + 1), 5'(i + 2), 5'(i), 16'(16'h100 * i), 26'h0);
    chk("bp_in_ready_low", in_ready, 1'b0);
    in_valid = 1'b1; in_sel = 9'b010000000; in_rs = 5'd4; in_rt = 5'd5; in_rd = 5'd6;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_fifth_held", last_acc, 1'b0);
    end
    out_ready = 1'b1;
    for (int n = 0; n < 20 && !last_acc; n++) step();
    in_valid = 1'b0;
    chk("bp_fifth_accepted", last_acc, 1'b1);
    drain();

    // Invalid selects.
    clr_pulse();
    in_valid = 1'b1; in_sel = 9'b000000011;
    step();
    in_sel = 9'b0;
    step();
    in_valid = 1'b0;
    step();
    chk("inv_err_cnt", err_cnt, 8'd2);
    chk("inv_out_valid", out_valid, 1'b0);
    chk("inv_in_ready", in_ready, 1'b1);

    // clr with three words queued and a simultaneous push/pop attempt.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(9'b000000100, 5'(i), 5'(i + 9), 5'd0, 16'(i * 3), 26'h0);
    clr = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_sel = 9'b000000001; in_imm = 16'hABCD;
    step();
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("clr_word_cnt", word_cnt, 16'd0);
    chk("clr_out_valid", out_valid, 1'b0);
    push(9'b000000001, 5'd2, 5'd3, 5'd0, 16'h5A5A, 26'h0);
    chk("clr_first_addr", out_addr, 32'h0000_3000);
    drain();

    // Randomized traffic with occasional clr.
    for (int n = 0; n < 300; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = ($urandom_range(0, 9) < 8) ? 9'(1 << $urandom_range(0, 8)) : 9'($urandom);
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_rd     = 5'($urandom);
      in_imm    = 16'($urandom);
      in_target = 26'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      clr       = ($urandom_range(0, 39) == 0);
      step();
    end
    in_valid = 1'b0; clr = 1'b0;
    drain();

    // Error counter saturation.
    in_valid = 1'b1; in_sel = 9'b0;
    for (int n = 0; n < 260; n++) step();
    in_valid = 1'b0;
    step();
    chk("err_saturated", err_cnt, 8'hFF);

    // Reset mid-burst.
    out_ready = 1'b0;
    push(9'b000000010, 5'd1, 5'd2, 5'd0, 16'h10, 26'h0);
    push(9'b001000000, 5'd3, 5'd4, 5'd5, 16'h0, 26'h0);
    out_ready = 1'b1; in_valid = 1'b1; in_sel = 9'b000000001; reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("rst2_out_valid", out_valid, 1'b0);
    chk("rst2_out_data", out_data, 32'h0);
    chk("rst2_out_addr", out_addr, BASE);
    chk("rst2_err_cnt", err_cnt, 8'd0);
    chk("rst2_word_cnt", word_cnt, 16'd0);
    chk("rst2_in_ready", in_ready, 1'b1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
